neuron_learn_layer_seq: RTL and testbench
=========================================

Name: neuron_learn_layer_seq

Overview:
Parametrised, time-multiplexed successor to the fixed 24-wide learning layer. M neurons × N inputs share one multiply-accumulate datapath and are sequenced by an FSM with valid/ready handshakes. It performs a forward pass and, when requested, a backward pass that updates weights and produces averaged expected_in for the upstream layer. It sits between layers in the learning network, where area matters more than latency.

Parameters:
N, 16, inputs per neuron (≥1)
M, 24, neurons in layer (≥1; need not be a power of two)
LR_SHIFT, 2, learning-rate right shift applied to weight deltas (0..8)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  high only in IDLE
learn  in  1  sampled with input; 1 = forward+backward pass
in  in  zero2one_t[N]  layer inputs, 16b unsigned Q0.16
expected_out  in  zero2one_t[M]  targets, sampled with input
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  downstream accept
out  out  zero2one_t[M]  activations
expected_in  out  zero2one_t[N]  averaged back-propagated targets
weights  out  frac_t[M][N]  current weights, 16b signed Q2.14
activation_max  out  frac_t[M]  running max pre-activation
activation_min  out  frac_t[M]  running min pre-activation
busy  out  1  state ≠ IDLE

Behaviour:
- Reset (async assert, sync deassert): state IDLE; weights, out, expected_in = 0; activation_max = 0x8000; activation_min = 0x7FFF; out_valid = 0; busy = 0.
- FSM: IDLE -(in_valid)-> FWD -> ACT -> (learn ? BWD : DONE); BWD -> AVG -> DONE; DONE -(out_ready)-> IDLE.
- Acceptance: in, expected_out and learn are latched on the in_valid && in_ready edge. Inputs are not sampled at any other time.
- FWD: M*N cycles, one (m,n) product per cycle, n inner loop. Accumulator is signed, 32+clog2(N) bits. No saturation inside the sum.
- ACT: s_m = acc >>> 14 (Q.16).
  - out[m] = clamp(s_m, 0, 0xFFFF).
  - p_m = clamp(s_m >>> 2, -0x8000, 0x7FFF). activation_max/min are updated with p_m on every pass.
- BWD: M*N cycles. With e_m = expected_out[m] − out[m] (17b signed):
  - c = clamp(in[n] + ((e_m*w_mn) >>> 14), 0, 0xFFFF), computed from the pre-update w, is added to expected-sum[n].
  - w_mn += ((e_m*in[n]) >>> (18+LR_SHIFT)), saturating to frac_t range.
- AVG: expected_in[n] = expected-sum[n] / M, truncating, constant divide. On an inference pass expected_in keeps its previous value.
- Latency from acceptance edge to out_valid high: M*N+2 cycles (inference), 2*M*N+3 cycles (learn).
- out, expected_in, weights and activation_max/min are stable while out_valid=1. out_valid drops on the out_ready handshake edge.
- in_ready=0 outside IDLE, so a new sample never overlaps a result that has not yet been accepted.
- Reset mid-pass aborts the pass and restores all reset values, including weights.
- out_ready asserted before DONE is ignored.

Optional Feature:
WEIGHT_LOAD_EN
- Defined: adds ports wl_valid (in, 1), wl_neuron (in, clog2(M)), wl_index (in, clog2(N)) and wl_data (in, frac_t).
  - A write is applied on the clock edge only when state=IDLE and in_valid=0.
  - In-range writes to weights[wl_neuron][wl_index] take effect at that edge.
  - Writes whose wl_neuron or wl_index is out of range are ignored.
  - in_valid has priority over wl_valid.
- Undefined: these ports are absent, and weights change only through learning and reset.

Test Plan:
1. Reset pulse mid-idle -> all outputs zero, in_ready=1, busy=0, activation_max=0x8000, activation_min=0x7FFF.
2. M=2,N=2,LR_SHIFT=0, zero weights, inference, in={0x8000,0x8000} -> out={0,0}, out_valid exactly 6 cycles after acceptance, weights unchanged, activation_max=activation_min=0.
3. Same config, learn=1, in={0xFFFF,0}, expected_out={0xFFFF,0} -> w00=0x3FFF, all other weights 0, expected_in={0xFFFF,0}, out_valid 11 cycles after acceptance.
4. Follow-up inference, in={0xFFFF,0} -> out[0]=0xFFFB, out[1]=0, activation_max[0]=0x3FFE.
5. Hold out_ready=0 for 10 cycles in DONE, then assert reset_n=0 during a later BWD -> out_valid stays 1 with stable data and in_ready=0; the reset returns the block to IDLE with weights zeroed.
6. WEIGHT_LOAD_EN: write 0x7FFF to w00, then learn with e=+0xFFFF, in=0xFFFF -> w00 saturates at 0x7FFF. A write attempted during FWD is ignored.

Source files
------------

// File: rtl/neuron_learn_layer_seq.sv
// Time-multiplexed M x N learning layer: one shared MAC steps through the forward and backward passes.
// Define WEIGHT_LOAD_EN to add a direct weight-write port that is usable while idle.
module neuron_learn_layer_seq #(
  parameter int N        = 16,
  parameter int M        = 24,
  parameter int LR_SHIFT = 2,
  localparam int NW = (N > 1) ? $clog2(N) : 1,
  localparam int MW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      learn,
  input  logic [N-1:0][15:0]        in,
  input  logic [M-1:0][15:0]        expected_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [M-1:0][15:0]        out,
  output logic [N-1:0][15:0]        expected_in,
  output logic [M-1:0][N-1:0][15:0] weights,
  output logic [M-1:0][15:0]        activation_max,
  output logic [M-1:0][15:0]        activation_min,
  output logic                      busy
`ifdef WEIGHT_LOAD_EN
  ,
  input  logic                      wl_valid,
  input  logic [MW-1:0]             wl_neuron,
  input  logic [NW-1:0]             wl_index,
  input  logic [15:0]               wl_data
`endif
);

  localparam int AW = 32 + $clog2(N);
  localparam int SW = 17 + $clog2(M);
  localparam logic signed [AW-1:0] O_MAX = AW'(65535);
  localparam logic signed [AW-1:0] P_MAX = AW'(32767);
  localparam logic signed [AW-1:0] P_MIN = AW'(-32768);

  typedef enum logic [2:0] {IDLE, FWD, ACT, BWD, AVG, DONE} state_t;
  state_t state, state_nx;

  logic [N-1:0][15:0] in_q;
  logic [M-1:0][15:0] exp_q;
  logic               learn_q;
  logic [MW-1:0]      mi;
  logic [NW-1:0]      ni;
  logic               act_ph;
  logic               last_mn;
  logic               accept;
  logic [15:0]        w_rd, x_rd;

  assign accept    = (state == IDLE) && in_valid;
  assign last_mn   = (mi == MW'(M-1)) && (ni == NW'(N-1));
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign w_rd      = weights[mi][ni];
  assign x_rd      = in_q[ni];

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;

  // ACT lasts two cycles so the MAC pipeline drains before DONE/BWD.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = FWD;
      FWD:     if (last_mn) state_nx = ACT;
      ACT:     if (act_ph) state_nx = learn_q ? BWD : DONE;
      BWD:     if (last_mn) state_nx = AVG;
      AVG:     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_q    <= '0;
      exp_q   <= '0;
      learn_q <= 1'b0;
      mi      <= '0;
      ni      <= '0;
      act_ph  <= 1'b0;
    end else begin
      act_ph <= (state == ACT) && !act_ph;
      if (accept) begin
        in_q    <= in;
        exp_q   <= expected_out;
        learn_q <= learn;
        mi      <= '0;
        ni      <= '0;
      end else if (state == FWD || state == BWD) begin
        if (ni == NW'(N-1)) begin
          ni <= '0;
          mi <= (mi == MW'(M-1)) ? '0 : mi + MW'(1);
        end else begin
          ni <= ni + NW'(1);
        end
      end
    end
  end

  // Forward MAC: multiply -> accumulate -> activation writeback.
  logic [1:0]           vld_pipe;
  logic signed [31:0]   w_ext, x_ext, prod_q;
  logic                 first_a, last_a, last_b;
  logic [MW-1:0]        m_a, m_b;
  logic signed [AW-1:0] acc, acc_sum;

  assign w_ext   = 32'($signed(w_rd));
  assign x_ext   = 32'($signed({1'b0, x_rd}));
  assign acc_sum = (first_a ? '0 : acc) + AW'(prod_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      prod_q   <= '0;
      first_a  <= 1'b0;
      last_a   <= 1'b0;
      last_b   <= 1'b0;
      m_a      <= '0;
      m_b      <= '0;
      acc      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], state == FWD};
      prod_q   <= w_ext * x_ext;
      first_a  <= (ni == '0);
      last_a   <= (ni == NW'(N-1));
      m_a      <= mi;
      if (vld_pipe[0]) begin
        acc    <= acc_sum;
        last_b <= last_a;
        m_b    <= m_a;
      end
    end
  end

  logic signed [AW-1:0] s_c, p_w;
  logic [15:0]          o_c, p_c;

  assign s_c = acc >>> 14;
  assign p_w = s_c >>> 2;

  always_comb begin
    o_c = s_c[15:0];
    if (s_c[AW-1])       o_c = 16'h0000;
    else if (s_c > O_MAX) o_c = 16'hFFFF;
    p_c = p_w[15:0];
    if (p_w < P_MIN)      p_c = 16'h8000;
    else if (p_w > P_MAX) p_c = 16'h7FFF;
  end

  // Backward step: error feedback term and weight delta for the current (mi, ni).
  logic signed [16:0] e_bw;
  logic signed [33:0] ew, ex, c_raw, w_raw;
  logic [15:0]        c_bw, w_nx;

  assign e_bw  = $signed({1'b0, exp_q[mi]}) - $signed({1'b0, out[mi]});
  assign ew    = 34'(e_bw) * 34'($signed(w_rd));
  assign ex    = 34'(e_bw) * 34'($signed({1'b0, x_rd}));
  assign c_raw = (ew >>> 14) + 34'($signed({1'b0, x_rd}));
  assign w_raw = (ex >>> (18 + LR_SHIFT)) + 34'($signed(w_rd));

  always_comb begin
    c_bw = c_raw[15:0];
    if (c_raw[33])                c_bw = 16'h0000;
    else if (c_raw > 34'sd65535)  c_bw = 16'hFFFF;
    w_nx = w_raw[15:0];
    if (w_raw < -34'sd32768)      w_nx = 16'h8000;
    else if (w_raw > 34'sd32767)  w_nx = 16'h7FFF;
  end

`ifdef WEIGHT_LOAD_EN
  logic wl_hit;
  assign wl_hit = wl_valid && (state == IDLE) && !in_valid &&
                  (int'(wl_neuron) < M) && (int'(wl_index) < N);
`endif

  logic [N-1:0][SW-1:0] esum;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out            <= '0;
      expected_in    <= '0;
      esum           <= '0;
      weights        <= '0;
      activation_max <= {M{16'h8000}};
      activation_min <= {M{16'h7FFF}};
    end else begin
      if (accept) esum <= '0;
      if (vld_pipe[1] && last_b) begin
        out[m_b] <= o_c;
        if ($signed(p_c) > $signed(activation_max[m_b])) activation_max[m_b] <= p_c;
        if ($signed(p_c) < $signed(activation_min[m_b])) activation_min[m_b] <= p_c;
      end
      if (state == BWD) begin
        weights[mi][ni] <= w_nx;
        esum[ni]        <= esum[ni] + SW'(c_bw);
      end
      if (state == AVG)
        for (int n = 0; n < N; n++) expected_in[n] <= 16'(esum[n] / SW'(M));
`ifdef WEIGHT_LOAD_EN
      if (wl_hit) weights[wl_neuron][wl_index] <= wl_data;
`endif
    end
  end

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Randomized bench for neuron_learn_layer_seq against an arithmetic reference model.
module tb_neuron_learn_layer_seq;
  localparam int N  = 2;
  localparam int M  = 2;
  localparam int LR = 0;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;

  logic clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, learn = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [N-1:0][15:0]        in = '0;
  logic [M-1:0][15:0]        expected_out = '0;
  logic [M-1:0][15:0]        out, activation_max, activation_min;
  logic [N-1:0][15:0]        expected_in;
  logic [M-1:0][N-1:0][15:0] weights;
`ifdef WEIGHT_LOAD_EN
  logic          wl_valid = 1'b0;
  logic [MW-1:0] wl_neuron = '0;
  logic [NW-1:0] wl_index = '0;
  logic [15:0]   wl_data = '0;
`endif

  always #5 clock = ~clock;

  neuron_learn_layer_seq #(.N(N), .M(M), .LR_SHIFT(LR)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .learn(learn), .in(in), .expected_out(expected_out), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .expected_in(expected_in), .weights(weights),
    .activation_max(activation_max), .activation_min(activation_min), .busy(busy)
`ifdef WEIGHT_LOAD_EN
    , .wl_valid(wl_valid), .wl_neuron(wl_neuron), .wl_index(wl_index), .wl_data(wl_data)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int     mx[N], mt[M];
  longint mw[M][N], mout[M], mmax[M], mmin[M], mexp[N];

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < M; m++) begin
      mout[m] = 0; mmax[m] = -32768; mmin[m] = 32767;
      for (int n = 0; n < N; n++) mw[m][n] = 0;
    end
    for (int n = 0; n < N; n++) mexp[n] = 0;
  endtask

  task automatic model_pass(input bit lrn);
    longint s, p, e;
    longint sum[N];
    for (int m = 0; m < M; m++) begin
      s = 0;
      for (int n = 0; n < N; n++) s += mw[m][n] * mx[n];
      s = s >>> 14;
      mout[m] = clamp(s, 0, 65535);
      p = clamp(s >>> 2, -32768, 32767);
      if (p > mmax[m]) mmax[m] = p;
      if (p < mmin[m]) mmin[m] = p;
    end
    if (lrn) begin
      for (int n = 0; n < N; n++) sum[n] = 0;
      for (int m = 0; m < M; m++) begin
        e = mt[m] - mout[m];
        for (int n = 0; n < N; n++) begin
          sum[n] += clamp(mx[n] + ((e * mw[m][n]) >>> 14), 0, 65535);
          mw[m][n] = clamp(mw[m][n] + ((e * mx[n]) >>> (18 + LR)), -32768, 32767);
        end
      end
      for (int n = 0; n < N; n++) mexp[n] = sum[n] / M;
    end
  endtask

  task automatic check_all(input string ph);
    for (int m = 0; m < M; m++) begin
      chk($sformatf("%s out[%0d]", ph, m), out[m], mout[m]);
      chk($sformatf("%s amax[%0d]", ph, m), $signed(activation_max[m]), mmax[m]);
      chk($sformatf("%s amin[%0d]", ph, m), $signed(activation_min[m]), mmin[m]);
      for (int n = 0; n < N; n++)
        chk($sformatf("%s w[%0d][%0d]", ph, m, n), $signed(weights[m][n]), mw[m][n]);
    end
    for (int n = 0; n < N; n++)
      chk($sformatf("%s exp_in[%0d]", ph, n), expected_in[n], mexp[n]);
  endtask

  // One sample through the block; early=1 keeps out_ready high throughout.
  task automatic run_pass(input bit lrn, input bit early, input int hold);
    int cyc;
    @(negedge clock);
    chk("in_ready_idle", in_ready, 1);
    for (int n = 0; n < N; n++) in[n] = 16'(mx[n]);
    for (int m = 0; m < M; m++) expected_out[m] = 16'(mt[m]);
    learn = lrn; in_valid = 1'b1; out_ready = early;
    @(posedge clock); #1;
    in_valid = 1'b0; learn = ~lrn;
    for (int n = 0; n < N; n++) in[n] = 16'($urandom);
    for (int m = 0; m < M; m++) expected_out[m] = 16'($urandom);
    chk("busy", busy, 1);
    model_pass(lrn);
    cyc = 0;
    while (!out_valid && cyc < 1000) begin
      @(posedge clock); #1; cyc++;
    end
    chk("latency", cyc, lrn ? 2*M*N + 3 : M*N + 2);
    check_all("done");
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
      end
      check_all("hold");
      @(negedge clock); out_ready = 1'b1;
    end
    @(posedge clock); #1;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
    @(negedge clock); out_ready = 1'b0;
  endtask

  function automatic int pick();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 65535;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

`ifdef WEIGHT_LOAD_EN
  task automatic wl_write(input int m, input int n, input int d);
    @(negedge clock);
    wl_valid = 1'b1; wl_neuron = MW'(m); wl_index = NW'(n); wl_data = 16'(d);
    @(posedge clock); #1;
    wl_valid = 1'b0;
    mw[m][n] = longint'($signed(16'(d)));
  endtask
`endif

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    check_all("reset");

    // Zero weights, inference
    mx[0] = 'h8000; mx[1] = 'h8000; mt[0] = 0; mt[1] = 0;
    run_pass(1'b0, 1'b0, 3);
    chk("t2_out0", out[0], 0);
    chk("t2_amax0", $signed(activation_max[0]), 0);
    chk("t2_amin1", $signed(activation_min[1]), 0);

    // First learn step
    mx[0] = 'hFFFF; mx[1] = 0; mt[0] = 'hFFFF; mt[1] = 0;
    run_pass(1'b1, 1'b0, 2);
    chk("t3_w00", weights[0][0], 'h3FFF);
    chk("t3_w11", weights[1][1], 0);
    chk("t3_exp0", expected_in[0], 'hFFFF);
    chk("t3_exp1", expected_in[1], 0);

    // Follow-up inference, out_ready held early
    run_pass(1'b0, 1'b1, 0);
    chk("t4_out0", out[0], 'hFFFB);
    chk("t4_out1", out[1], 0);
    chk("t4_amax0", activation_max[0], 'h3FFE);

    // Long hold in DONE
    for (int n = 0; n < N; n++) mx[n] = pick();
    for (int m = 0; m < M; m++) mt[m] = pick();
    run_pass(1'b1, 1'b0, 10);

`ifdef WEIGHT_LOAD_EN
    wl_write(0, 0, 'h7FFF);
    wl_write(0, 1, 'h8000);
    chk("wl_w00", weights[0][0], 'h7FFF);
    chk("wl_w01", weights[0][1], 'h8000);
    // Write held during acceptance and the pass must be ignored
    wl_valid = 1'b1; wl_neuron = '0; wl_index = '0; wl_data = 16'h1234;
    mx[0] = 'hFFFF; mx[1] = 'hFFFF; mt[0] = 'hFFFF; mt[1] = 0;
    run_pass(1'b1, 1'b0, 1);
    wl_valid = 1'b0;
    chk("wl_sat_w00", weights[0][0], 'h7FFF);
`endif

    for (int k = 0; k < 40; k++) begin
      for (int n = 0; n < N; n++) mx[n] = pick();
      for (int m = 0; m < M; m++) mt[m] = pick();
      run_pass(1'(($urandom_range(0, 2)) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset during the backward pass
    for (int n = 0; n < N; n++) mx[n] = pick();
    for (int m = 0; m < M; m++) mt[m] = 'hFFFF;
    @(negedge clock);
    for (int n = 0; n < N; n++) in[n] = 16'(mx[n]);
    for (int m = 0; m < M; m++) expected_out[m] = 16'(mt[m]);
    learn = 1'b1; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (M*N + 4) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    check_all("mid_rst");
    @(negedge clock); reset_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < N; n++) mx[n] = pick();
      for (int m = 0; m < M; m++) mt[m] = pick();
      run_pass(1'b1, 1'b0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
